lcd_bus_receiver: RTL and testbench



---
 rtl/lcd_bus_receiver.sv | 178 +++++++++++++++++
 tb/tb_lcd_bus_receiver.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_receiver.sv
// Panel-side decoder for the 8080-style write bus: window/control state plus one event per RGB565 pixel.
// Latency: 1 clk from wr sampled high to pulse (3 clk with LCD_RX_SYNC_EN). No backpressure: every strobe is consumed.
module lcd_bus_receiver #(
  parameter int COORD_W = 9,
  parameter int COL_MAX = 239,
  parameter int ROW_MAX = 319
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr,
  input  logic               dcx,
  input  logic [7:0]         d,
  output logic               pix_valid,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [15:0]        pix_color,
  output logic               frame_start,
  output logic               cmd_valid,
  output logic [7:0]         cmd_byte,
  output logic               disp_on,
  output logic               sleep_out
);

  localparam logic [COORD_W-1:0] COL_LIM = COORD_W'(COL_MAX);
  localparam logic [COORD_W-1:0] ROW_LIM = COORD_W'(ROW_MAX);

  typedef enum logic [2:0] {IDLE, CASET, PASET, RAMWR, IGNORE} state_t;

  logic [9:0] stage_in;

`ifdef LCD_RX_SYNC_EN
  logic [9:0] sync1, sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {wr, dcx, d};
      sync2 <= sync1;
    end
  end

  assign stage_in = sync2;
`else
  assign stage_in = {wr, dcx, d};
`endif

  logic       wr_s, wr_q, dcx_s;
  logic [7:0] d_s;
  logic       byte_evt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_s  <= 1'b0;
      dcx_s <= 1'b0;
      d_s   <= '0;
      wr_q  <= 1'b0;
    end else begin
      {wr_s, dcx_s, d_s} <= stage_in;
      wr_q <= wr_s;
    end
  end

  assign byte_evt = wr_s & ~wr_q;

  state_t             state;
  logic [2:0]         byte_cnt;
  logic [7:0]         par0, par1, par2;
  logic [7:0]         held;
  logic [COORD_W-1:0] xs, xe, ys, ye;
  logic [COORD_W-1:0] x, y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      byte_cnt    <= '0;
      par0        <= '0;
      par1        <= '0;
      par2        <= '0;
      held        <= '0;
      xs          <= '0;
      xe          <= COL_LIM;
      ys          <= '0;
      ye          <= ROW_LIM;
      x           <= '0;
      y           <= '0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_color   <= '0;
      frame_start <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_byte    <= '0;
      disp_on     <= 1'b0;
      sleep_out   <= 1'b0;
    end else begin
      pix_valid   <= 1'b0;
      cmd_valid   <= 1'b0;
      frame_start <= 1'b0;
      if (byte_evt) begin
        if (!dcx_s) begin
          // Clearing the counter also discards a half-collected parameter or pixel.
          cmd_valid <= 1'b1;
          cmd_byte  <= d_s;
          byte_cnt  <= '0;
          case (d_s)
            8'h2A: state <= CASET;
            8'h2B: state <= PASET;
            8'h2C: begin
              state       <= RAMWR;
              frame_start <= 1'b1;
              x           <= xs;
              y           <= ys;
            end
            8'h01: begin
              xs        <= '0;
              xe        <= COL_LIM;
              ys        <= '0;
              ye        <= ROW_LIM;
              disp_on   <= 1'b0;
              sleep_out <= 1'b0;
              state     <= IGNORE;
            end
            8'h10: begin sleep_out <= 1'b0; state <= IGNORE; end
            8'h11: begin sleep_out <= 1'b1; state <= IGNORE; end
            8'h28: begin disp_on   <= 1'b0; state <= IGNORE; end
            8'h29: begin disp_on   <= 1'b1; state <= IGNORE; end
            default: state <= IGNORE;
          endcase
        end else begin
          case (state)
            CASET, PASET: begin
              // Counter saturates at 4 so trailing parameter bytes fall through.
              if (byte_cnt < 3'd4) byte_cnt <= byte_cnt + 3'd1;
              case (byte_cnt)
                3'd0: par0 <= d_s;
                3'd1: par1 <= d_s;
                3'd2: par2 <= d_s;
                3'd3: begin
                  if (state == CASET) begin
                    xs <= COORD_W'({par0, par1});
                    xe <= COORD_W'({par2, d_s});
                  end else begin
                    ys <= COORD_W'({par0, par1});
                    ye <= COORD_W'({par2, d_s});
                  end
                end
                default: ;
              endcase
            end
            RAMWR: begin
              if (!byte_cnt[0]) begin
                held     <= d_s;
                byte_cnt <= 3'd1;
              end else begin
                byte_cnt  <= 3'd0;
                pix_valid <= 1'b1;
                pix_color <= {held, d_s};
                pix_x     <= x;
                pix_y     <= y;
                if (x == xe || x == COL_LIM) begin
                  x <= xs;
                  if (y == ye || y == ROW_LIM) y <= ys;
                  else                         y <= y + COORD_W'(1);
                end else begin
                  x <= x + COORD_W'(1);
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed-vector bench for lcd_bus_receiver: byte table with expected pixel/command events, plus reset and latency sequences.
module tb_lcd_bus_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr = 1'b0;
  logic        dcx = 1'b0;
  logic [7:0]  d = '0;
  logic        pix_valid;
  logic [8:0]  pix_x, pix_y;
  logic [15:0] pix_color;
  logic        frame_start, cmd_valid;
  logic [7:0]  cmd_byte;
  logic        disp_on, sleep_out;

  lcd_bus_receiver #(.COORD_W(9), .COL_MAX(239), .ROW_MAX(319)) dut (
    .clk(clk), .rst(rst), .wr(wr), .dcx(dcx), .d(d),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .frame_start(frame_start), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
    .disp_on(disp_on), .sleep_out(sleep_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dcx;
    logic [7:0]  d;
    logic        pix;
    logic [8:0]  x;
    logic [8:0]  y;
    logic [15:0] color;
    logic        fs;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  int          pc = 0, cc = 0, fc = 0;
  logic [8:0]  lx = '0, ly = '0;
  logic [15:0] lc = '0;

  always @(negedge clk) begin
    if (pix_valid) begin
      pc++;
      lx = pix_x;
      ly = pix_y;
      lc = pix_color;
    end
    if (cmd_valid) cc++;
    if (frame_start) fc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic dc, input logic [7:0] b, input logic p,
                              input int px_x, input int px_y, input logic [15:0] c, input logic f);
    vec_t v;
    v.dcx = dc; v.d = b; v.pix = p; v.x = 9'(px_x); v.y = 9'(px_y); v.color = c; v.fs = f;
    vecs.push_back(v);
  endfunction

  function automatic void cmd(input logic [7:0] b);
    add(1'b0, b, 1'b0, 0, 0, 16'h0, b == 8'h2C);
  endfunction

  function automatic void dat(input logic [7:0] b);
    add(1'b1, b, 1'b0, 0, 0, 16'h0, 1'b0);
  endfunction

  function automatic void px(input logic [7:0] b, input int px_x, input int px_y, input logic [15:0] c);
    add(1'b1, b, 1'b1, px_x, px_y, c, 1'b0);
  endfunction

  // wr high 2 cycles, low 3 cycles: leaves room for the synchronized pulse before the next byte.
  task automatic write_byte(input logic dc, input logic [7:0] b);
    @(negedge clk);
    dcx = dc;
    d   = b;
    wr  = 1'b1;
    repeat (2) @(negedge clk);
    wr = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic run(input int first, input int last);
    for (int i = first; i < last; i++) begin
      int p0, c0, f0;
      p0 = pc; c0 = cc; f0 = fc;
      write_byte(vecs[i].dcx, vecs[i].d);
      check($sformatf("v%0d pix_count", i), pc - p0, {31'd0, vecs[i].pix});
      check($sformatf("v%0d cmd_count", i), cc - c0, {31'd0, ~vecs[i].dcx});
      check($sformatf("v%0d frame_start_count", i), fc - f0, {31'd0, vecs[i].fs});
      if (vecs[i].pix) begin
        check($sformatf("v%0d pix_x", i), lx, vecs[i].x);
        check($sformatf("v%0d pix_y", i), ly, vecs[i].y);
        check($sformatf("v%0d pix_color", i), lc, vecs[i].color);
      end
    end
  endtask

  int e0, e1, e2, e3, e4, e5, e6, e7, e8, e9;
  int ex[8] = '{5, 6, 7, 5, 6, 7, 5, 6};
  int ey[8] = '{2, 2, 2, 3, 3, 3, 2, 2};
  int lat, exp_lat;

  initial begin
    // first pixel after reset lands at the origin
    cmd(8'h2C); dat(8'h12); px(8'h34, 0, 0, 16'h1234);
    e0 = vecs.size();
    // 3x2 window with trailing ignored parameter bytes; stream wraps back to (5,2)
    cmd(8'h2A); dat(8'h00); dat(8'h05); dat(8'h00); dat(8'h07); dat(8'h00); dat(8'h09);
    cmd(8'h2B); dat(8'h00); dat(8'h02); dat(8'h00); dat(8'h03);
    cmd(8'h2C);
    for (int i = 0; i < 8; i++) begin dat(8'h12); px(8'h34, ex[i], ey[i], 16'h1234); end
    e1 = vecs.size();
    // SWRESET to defaults, then an aborted CASET leaves the window alone
    cmd(8'h01); cmd(8'h2A); dat(8'h00); dat(8'h05); cmd(8'h2C); dat(8'hAB); px(8'hCD, 0, 0, 16'hABCD);
    e2 = vecs.size();
    // half pixel dropped by DISPON; data in IGNORE discarded
    cmd(8'h2C); dat(8'hAB); cmd(8'h29); dat(8'h12); dat(8'h34);
    e3 = vecs.size();
    cmd(8'h2C); dat(8'h56); px(8'h78, 0, 0, 16'h5678);
    e4 = vecs.size();
    cmd(8'h11); cmd(8'h29); cmd(8'h2A); dat(8'h00); dat(8'h10); dat(8'h00); dat(8'h20);
    e5 = vecs.size();
    cmd(8'h01);
    e6 = vecs.size();
    cmd(8'h2C); dat(8'h00); px(8'h01, 0, 0, 16'h0001);
    // x wraps at COL_MAX despite larger xe (0x3FF truncated); y wraps at ROW_MAX to ys=319
    cmd(8'h2A); dat(8'h00); dat(8'hEE); dat(8'h03); dat(8'hFF);
    cmd(8'h2B); dat(8'h01); dat(8'h3F); dat(8'h01); dat(8'hFF);
    cmd(8'h2C);
    dat(8'hAA); px(8'h55, 238, 319, 16'hAA55);
    dat(8'hAA); px(8'h55, 239, 319, 16'hAA55);
    dat(8'hAA); px(8'h55, 238, 319, 16'hAA55);
    dat(8'hAA); px(8'h55, 239, 319, 16'hAA55);
    e7 = vecs.size();
    cmd(8'h2C); dat(8'h12);
    e8 = vecs.size();
    // after reset: data in IDLE discarded, window back to defaults
    dat(8'h34); dat(8'h56); cmd(8'h2C); dat(8'h9A); px(8'hBC, 0, 0, 16'h9ABC);
    e9 = vecs.size();

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset pix_valid", pix_valid, 0);
    check("reset pix_x", pix_x, 0);
    check("reset pix_y", pix_y, 0);
    check("reset pix_color", pix_color, 0);
    check("reset frame_start", frame_start, 0);
    check("reset cmd_valid", cmd_valid, 0);
    check("reset cmd_byte", cmd_byte, 0);
    check("reset disp_on", disp_on, 0);
    check("reset sleep_out", sleep_out, 0);

    run(0, e0);
    run(e0, e1);
    run(e1, e2);
    run(e2, e3);
    check("dispon disp_on", disp_on, 1);
    check("dispon cmd_byte", cmd_byte, 8'h29);
    run(e3, e4);
    run(e4, e5);
    check("pre-swreset disp_on", disp_on, 1);
    check("pre-swreset sleep_out", sleep_out, 1);
    run(e5, e6);
    check("swreset disp_on", disp_on, 0);
    check("swreset sleep_out", sleep_out, 0);
    run(e6, e7);
    run(e7, e8);

    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midreset cmd_byte", cmd_byte, 0);
    check("midreset pix_x", pix_x, 0);
    check("midreset pix_color", pix_color, 0);
    run(e8, e9);

`ifdef LCD_RX_SYNC_EN
    exp_lat = 3;
`else
    exp_lat = 1;
`endif
    @(negedge clk);
    dcx = 1'b0;
    d   = 8'h00;
    wr  = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      if (cmd_valid && lat == 0) lat = i;
      if (i == 2) wr = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("cmd latency", lat, exp_lat);
    check("latency cmd_byte", cmd_byte, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
